// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter for the register-file write port
// (WE3/A3/WD3), shared by the ALU (index 0), load unit (1) and debug port (2).
// Grants are combinational. The write port is driven from registers.
// A saturating counter records cycles in which two or more sources contend.
//
// Build option: define REGWB_DEBUG_PORT_EN to include the debug port in the
// rotation. When it is undefined, the debug port is ignored and the pointer
// alternates between the ALU and the load unit only.
module regfile_wb_arbiter #(
    parameter int N_REQ = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_req,
    input  logic [4:0]       alu_a3,
    input  logic [31:0]      alu_wd,
    output logic             alu_gnt,
    input  logic             ld_req,
    input  logic [4:0]       ld_a3,
    input  logic [31:0]      ld_wd,
    output logic             ld_gnt,
    input  logic             dbg_req,
    input  logic [4:0]       dbg_a3,
    input  logic [31:0]      dbg_wd,
    output logic             dbg_gnt,
    output logic             we3,
    output logic [4:0]       a3,
    output logic [31:0]      wd3,
    output logic [CNT_W-1:0] conflict_cnt
);

`ifdef REGWB_DEBUG_PORT_EN
    localparam logic DBG_EN = 1'b1;
`else
    localparam logic DBG_EN = 1'b0;
`endif

    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [1:0]       win;
    logic             any_gnt;
    logic [4:0]       win_a3;
    logic [31:0]      win_wd;
    logic             conflict;

    logic [1:0]       ptr_q, ptr_d;
    logic             we3_q, we3_d;
    logic [4:0]       a3_q, a3_d;
    logic [31:0]      wd3_q, wd3_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The debug request is masked here, so a disabled port can neither win nor count as contention.
    assign req = {dbg_req & DBG_EN, ld_req, alu_req};

    // Search for the winner in the order ptr, ptr+1, ptr+2 (mod 3); reset blocks all grants.
    always_comb begin
        logic [2:0] sum;
        logic [1:0] idx;
        gnt     = '0;
        win     = 2'd0;
        any_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sum = {1'b0, ptr_q} + 3'(k);
            if (sum >= 3'd3) sum = sum - 3'd3;
            idx = sum[1:0];
            if (!any_gnt && !reset && req[idx]) begin
                gnt[idx] = 1'b1;
                win      = idx;
                any_gnt  = 1'b1;
            end
        end
    end

    // Select the address and data of the winning source.
    always_comb begin
        win_a3 = alu_a3;
        win_wd = alu_wd;
        case (win)
            2'd1:    begin win_a3 = ld_a3;  win_wd = ld_wd;  end
            2'd2:    begin win_a3 = dbg_a3; win_wd = dbg_wd; end
            default: begin win_a3 = alu_a3; win_wd = alu_wd; end
        endcase
    end

    assign conflict = (req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2]);

    // Compute the next state of the pointer, the write-port registers and the contention counter.
    always_comb begin
        ptr_d = ptr_q;
        if (any_gnt) begin
`ifdef REGWB_DEBUG_PORT_EN
            ptr_d = (win == 2'd2) ? 2'd0 : win + 2'd1;
`else
            ptr_d = {1'b0, ~win[0]};
`endif
        end
        we3_d = any_gnt && (win_a3 != 5'd0);
        a3_d  = any_gnt ? win_a3 : a3_q;
        wd3_d = any_gnt ? win_wd : wd3_q;
        cnt_d = cnt_q;
        if (conflict && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    // Register the state, with a synchronous clear on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 2'd0;
            we3_q <= 1'b0;
            a3_q  <= 5'd0;
            wd3_q <= 32'd0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            we3_q <= we3_d;
            a3_q  <= a3_d;
            wd3_q <= wd3_d;
            cnt_q <= cnt_d;
        end
    end

    assign alu_gnt      = gnt[0];
    assign ld_gnt       = gnt[1];
    assign dbg_gnt      = gnt[2];
    // If reset rises while a granted write is on the port, that write is dropped.
    assign we3          = we3_q & ~reset;
    assign a3           = a3_q;
    assign wd3          = wd3_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter. A second instance with a 4-bit
// counter, driven by the same inputs, checks that the counter saturates.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        alu_req, ld_req, dbg_req;
    logic [4:0]  alu_a3, ld_a3, dbg_a3;
    logic [31:0] alu_wd, ld_wd, dbg_wd;
    logic        alu_gnt, ld_gnt, dbg_gnt, we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic [15:0] conflict_cnt;
    logic        s_alu_gnt, s_ld_gnt, s_dbg_gnt, s_we3;
    logic [4:0]  s_a3;
    logic [31:0] s_wd3;
    logic [3:0]  s_cnt;

    logic [31:0] rf [32];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.N_REQ(3), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .alu_req(alu_req), .alu_a3(alu_a3), .alu_wd(alu_wd), .alu_gnt(alu_gnt),
        .ld_req(ld_req), .ld_a3(ld_a3), .ld_wd(ld_wd), .ld_gnt(ld_gnt),
        .dbg_req(dbg_req), .dbg_a3(dbg_a3), .dbg_wd(dbg_wd), .dbg_gnt(dbg_gnt),
        .we3(we3), .a3(a3), .wd3(wd3), .conflict_cnt(conflict_cnt)
    );

    regfile_wb_arbiter #(.N_REQ(3), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset),
        .alu_req(alu_req), .alu_a3(alu_a3), .alu_wd(alu_wd), .alu_gnt(s_alu_gnt),
        .ld_req(ld_req), .ld_a3(ld_a3), .ld_wd(ld_wd), .ld_gnt(s_ld_gnt),
        .dbg_req(dbg_req), .dbg_a3(dbg_a3), .dbg_wd(dbg_wd), .dbg_gnt(s_dbg_gnt),
        .we3(s_we3), .a3(s_a3), .wd3(s_wd3), .conflict_cnt(s_cnt)
    );

    // Simple register-file model written from the write port.
    always @(posedge clk) begin
        if (we3) rf[a3] <= wd3;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] a3_of(input int idx);
        return (idx == 0) ? 5'd10 : (idx == 1) ? 5'd11 : 5'd12;
    endfunction

    function automatic logic [31:0] wd_of(input int idx);
        return (idx == 0) ? 32'hA0A0_0001 : (idx == 1) ? 32'hB1B1_0002 : 32'hC2C2_0003;
    endfunction

    task automatic set_reqs(input logic a, input logic l, input logic d);
        alu_req = a;
        ld_req  = l;
        dbg_req = d;
    endtask

`ifdef REGWB_DEBUG_PORT_EN
    localparam int NCONT = 6;
    int exp_win [NCONT] = '{1, 2, 0, 1, 2, 0};
`else
    localparam int NCONT = 4;
    int exp_win [NCONT] = '{1, 0, 1, 0};
`endif

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        reset = 1'b1;
        set_reqs(1'b1, 1'b1, 1'b1);
        alu_a3 = 5'd1; ld_a3 = 5'd2; dbg_a3 = 5'd3;
        alu_wd = 32'h1; ld_wd = 32'h2; dbg_wd = 32'h3;

        // Hold reset for two cycles with every source requesting.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            chk("rst_gnt", {29'd0, dbg_gnt, ld_gnt, alu_gnt}, 32'd0);
            chk("rst_we3", {31'd0, we3}, 32'd0);
            chk("rst_a3", {27'd0, a3}, 32'd0);
            chk("rst_wd3", wd3, 32'd0);
            chk("rst_cnt", {16'd0, conflict_cnt}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        set_reqs(1'b0, 1'b0, 1'b0);
        #1;
        chk("post_rst_we3", {31'd0, we3}, 32'd0);
        chk("post_rst_cnt", {16'd0, conflict_cnt}, 32'd0);
        @(negedge clk); #1;
        chk("post_rst1_we3", {31'd0, we3}, 32'd0);
        chk("post_rst1_wd3", wd3, 32'd0);

        // A single ALU write, with the ALU holding priority after reset.
        @(negedge clk);
        alu_req = 1'b1; alu_a3 = 5'd5; alu_wd = 32'hDEADBEEF;
        #1;
        chk("single_gnt", {29'd0, dbg_gnt, ld_gnt, alu_gnt}, 32'd1);
        @(negedge clk);
        alu_req = 1'b0;
        #1;
        chk("single_we3", {31'd0, we3}, 32'd1);
        chk("single_a3", {27'd0, a3}, 32'd5);
        chk("single_wd3", wd3, 32'hDEADBEEF);
        @(negedge clk); #1;
        chk("single_rf5", rf[5], 32'hDEADBEEF);
        chk("single_we3_off", {31'd0, we3}, 32'd0);

        // Round-robin under full contention. The pointer is 1 after the ALU grant.
        alu_a3 = a3_of(0); ld_a3 = a3_of(1); dbg_a3 = a3_of(2);
        alu_wd = wd_of(0); ld_wd = wd_of(1); dbg_wd = wd_of(2);
        for (int i = 0; i < NCONT; i++) begin
            @(negedge clk);
            set_reqs(1'b1, 1'b1, 1'b1);
            #1;
            chk($sformatf("rr_gnt%0d", i), {29'd0, dbg_gnt, ld_gnt, alu_gnt}, 32'd1 << exp_win[i]);
            if (i > 0) begin
                chk($sformatf("rr_a3_%0d", i), {27'd0, a3}, {27'd0, a3_of(exp_win[i-1])});
                chk($sformatf("rr_wd3_%0d", i), wd3, wd_of(exp_win[i-1]));
            end
        end
        @(negedge clk);
        set_reqs(1'b0, 1'b0, 1'b0);
        #1;
        chk("rr_last_a3", {27'd0, a3}, {27'd0, a3_of(exp_win[NCONT-1])});
        chk("rr_cnt", {16'd0, conflict_cnt}, NCONT);

        // A load write to x0 is granted, but the write enable stays low.
        @(negedge clk);
        ld_req = 1'b1; ld_a3 = 5'd0; ld_wd = 32'h1234;
        #1;
        chk("x0_gnt", {29'd0, dbg_gnt, ld_gnt, alu_gnt}, 32'd2);
        @(negedge clk);
        ld_req = 1'b0;
        #1;
        chk("x0_we3", {31'd0, we3}, 32'd0);
        chk("x0_wd3", wd3, 32'h1234);
        // The pointer has moved past load, so ALU wins the next ALU+load collision.
        @(negedge clk);
        set_reqs(1'b1, 1'b1, 1'b0);
        ld_a3 = 5'd11;
        #1;
        chk("x0_next_gnt", {29'd0, dbg_gnt, ld_gnt, alu_gnt}, 32'd1);
        @(negedge clk);
        set_reqs(1'b0, 1'b0, 1'b0);
        #1;
        chk("coll_cnt", {16'd0, conflict_cnt}, NCONT + 1);

        // The debug port requests alone for three cycles.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dbg_req = 1'b1; dbg_a3 = 5'd9; dbg_wd = 32'h9999;
            #1;
`ifdef REGWB_DEBUG_PORT_EN
            chk("dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
`else
            chk("dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
            if (i > 0) chk("dbg_we3", {31'd0, we3}, 32'd0);
`endif
        end
        @(negedge clk);
        dbg_req = 1'b0;
        #1;
        chk("dbg_cnt", {16'd0, conflict_cnt}, NCONT + 1);

        // A write granted just before reset rises is dropped.
        @(negedge clk);
        alu_req = 1'b1; alu_a3 = 5'd7; alu_wd = 32'h77;
        #1;
        chk("disc_gnt", {29'd0, dbg_gnt, ld_gnt, alu_gnt}, 32'd1);
        @(negedge clk);
        alu_req = 1'b0; reset = 1'b1;
        #1;
        chk("disc_we3", {31'd0, we3}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("disc_a3", {27'd0, a3}, 32'd0);
        chk("disc_cnt", {16'd0, conflict_cnt}, 32'd0);
        chk("disc_rf7", rf[7], 32'd0);

        // ALU and load both request for 20 cycles; the 4-bit counter saturates at 15.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            set_reqs(1'b1, 1'b1, 1'b0);
            #1;
            if (i == 14) chk("sat_cnt14", {28'd0, s_cnt}, 32'd14);
            if (i == 16) chk("sat_cnt16", {28'd0, s_cnt}, 32'd15);
        end
        @(negedge clk);
        set_reqs(1'b0, 1'b0, 1'b0);
        #1;
        chk("sat_cnt_final", {28'd0, s_cnt}, 32'd15);
        chk("wide_cnt_final", {16'd0, conflict_cnt}, 32'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
